// File: rtl/race_pkg.sv
// Shared constants and types for the ring-oscillator race counter.
package race_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } race_state_e;

  // Bits needed to hold TIMEOUT_CYC-1, never less than one.
  function automatic int tmr_width(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/ro_race_counter_if.sv
// Control/status bundle between the race counter and its host and arbiter.
interface ro_race_counter_if #(
  parameter int CNT_W = race_pkg::CNT_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] target;
  logic             finished1;
  logic             finished2;
  logic             busy;
  logic [CNT_W-1:0] count1;
  logic [CNT_W-1:0] count2;
  logic             timeout;

  modport master (
    output start, target,
    input  finished1, finished2, busy, count1, count2, timeout
  );

  modport slave (
    input  start, target,
    output finished1, finished2, busy, count1, count2, timeout
  );

endinterface

// File: rtl/ro_edge_sync.sv
// Brings one raw ring-oscillator output into clk and emits a one-cycle pulse
// per rising edge (synchronizer followed by a registered edge detector).
module ro_edge_sync
  import race_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], ro_in};
    prev_d = sync_q[SYNC_DEPTH-1];
    rise_d = sync_q[SYNC_DEPTH-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/ro_race_counter.sv
// Races two ring oscillators to a common edge count and flags the winner(s).
// Optional RUN watchdog enabled by defining RACE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | counting synchronized RO edges toward the latched target
// DONE    | race over; flags and counts held until the next start
module ro_race_counter
  import race_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ro1,
  input  logic              ro2,
  ro_race_counter_if.slave  bus
);

  race_state_e      state_q, state_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic             fin1_q, fin1_d;
  logic             fin2_q, fin2_d;
  logic             rise1, rise2;
  logic             inc1, inc2, hit1, hit2;
  logic             launch;

  if (TIMEOUT_CYC == 0) begin : g_cfg_err
    $error("TIMEOUT_CYC must be at least 1");
  end

  ro_edge_sync u_sync1 (.clk(clk), .rst_n(rst_n), .ro_in(ro1), .rise(rise1));
  ro_edge_sync u_sync2 (.clk(clk), .rst_n(rst_n), .ro_in(ro2), .rise(rise2));

`ifdef RACE_TIMEOUT_EN
  localparam int TMR_W = tmr_width(TIMEOUT_CYC);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    fin1_d  = fin1_q;
    fin2_d  = fin2_q;
    launch  = 1'b0;
`ifdef RACE_TIMEOUT_EN
    tmr_d   = tmr_q;
    to_d    = to_q;
`endif
    // Counts stay strictly below target in RUN, so the +1 never wraps.
    inc1 = rise1 && (cnt1_q != tgt_q);
    inc2 = rise2 && (cnt2_q != tgt_q);
    hit1 = inc1 && ((cnt1_q + CNT_W'(1)) == tgt_q);
    hit2 = inc2 && ((cnt2_q + CNT_W'(1)) == tgt_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) launch = 1'b1;
      end
      ST_RUN: begin
        if (fin1_q || fin2_q) begin
          state_d = ST_DONE;
        end else begin
          if (inc1) cnt1_d = cnt1_q + CNT_W'(1);
          if (inc2) cnt2_d = cnt2_q + CNT_W'(1);
          if (hit1) fin1_d = 1'b1;
          if (hit2) fin2_d = 1'b1;
`ifdef RACE_TIMEOUT_EN
          if (tmr_q == '0) begin
            if (!hit1 && !hit2) begin
              state_d = ST_DONE;
              to_d    = 1'b1;
            end
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_RUN;
      tgt_d   = (bus.target == '0) ? CNT_W'(1) : bus.target;
      cnt1_d  = '0;
      cnt2_d  = '0;
      fin1_d  = 1'b0;
      fin2_d  = 1'b0;
`ifdef RACE_TIMEOUT_EN
      tmr_d   = TMR_W'(TIMEOUT_CYC - 1);
      to_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      fin1_q  <= 1'b0;
      fin2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      fin1_q  <= fin1_d;
      fin2_q  <= fin2_d;
    end
  end

`ifdef RACE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      to_q  <= to_d;
    end
  end

  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.finished1 = fin1_q;
  assign bus.finished2 = fin2_q;
  assign bus.count1    = cnt1_q;
  assign bus.count2    = cnt2_q;
  assign bus.busy      = (state_q == ST_RUN);

endmodule

// File: doc/ro_race_counter.md
RO_RACE_COUNTER -- requirements
Module: ro_race_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the edge counters and of target.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535: maximum RUN duration in clk cycles. Used only with RACE_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1: single system clock. All logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that launches a race.
REQ-006 SHALL have port target, input, CNT_W: number of RO rising edges to reach. Sampled on an accepted start.
REQ-007 SHALL have ports ro1 and ro2, input, 1 each: raw, asynchronous ring-oscillator outputs.
REQ-008 SHALL have ports finished1 and finished2, output, 1 each: counter 1 or 2 reached target. Both feed the downstream race arbiter.
REQ-009 SHALL have port busy, output, 1: high while in RUN.
REQ-010 SHALL have ports count1 and count2, output, CNT_W each: live edge counts.
REQ-011 SHALL have port timeout, output, 1: the race ended without any counter finishing.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL move IDLE->RUN on start=1, latching target, clearing both counters and clearing finished1, finished2 and timeout.
REQ-014 SHALL also accept start in DONE (DONE->RUN), with the same clearing as REQ-013.
REQ-015 SHALL ignore start while in RUN.
REQ-016 SHALL treat a latched target of 0 as 1.
REQ-017 SHALL pass each RO through a 2-FF synchronizer and then a registered rising-edge detector. A counter SHALL increment 3 clk cycles after its RO rise is first sampled, and only while in RUN.
REQ-018 SHALL, in RUN, set finishedN in the same cycle that countN increments to the latched target.
REQ-019 SHALL move RUN->DONE in the cycle after any finishedN is set. Counters freeze on that transition.
REQ-020 SHALL assert finished1 and finished2 together when both counters reach target in the same cycle. Tie resolution belongs downstream.
REQ-021 SHALL hold finished1, finished2 and timeout sticky until the next accepted start or reset.
REQ-022 SHALL never let a counter exceed the latched target. No wrap-around is possible.
REQ-023 SHALL hold busy = 1 exactly while in RUN.

Reset
REQ-024 SHALL, while rst_n=0 at a clk edge, force: state IDLE, count1 = count2 = 0, finished1 = finished2 = 0, busy = 0, timeout = 0, synchronizer and edge registers 0.
REQ-025 SHALL abort a race on reset mid-RUN, with no finished pulse emitted.
REQ-026 SHALL NOT count a spurious edge from an RO that is already high when reset releases. The edge registers start at 0, and counting is gated by RUN.

Configuration
REQ-027 SHALL, with macro RACE_TIMEOUT_EN defined, run a cycle counter in RUN. On reaching TIMEOUT_CYC with neither finishedN set, the block SHALL go to DONE with timeout=1 and finished1 = finished2 = 0.
REQ-028 SHALL, without RACE_TIMEOUT_EN, tie timeout to constant 0, remain in RUN indefinitely and omit the cycle counter.

Structure
REQ-029 SHALL take CNT_W default, the state encoding typedef (IDLE/RUN/DONE) and the synchronizer depth constant (2) from shared package race_pkg.
REQ-030 SHALL instantiate sub-module ro_edge_sync twice, once per RO. ro_edge_sync contains the synchronizer and edge detector and has ports clk, rst_n, ro_in and rise.

Verification
REQ-031 SHALL cover this scenario: target=4, ro1 period 10 clk, ro2 period 14 clk, then start -> finished1=1 with count1=4, count2=2 or 3, finished2=0, busy low one cycle later.
REQ-032 SHALL cover this scenario: identical ro1/ro2 waveforms, target=3 -> finished1 and finished2 rise in the same cycle, both counts 3.
REQ-033 SHALL cover this scenario: target=0, single ro2 rise -> finished2=1 with count2=1.
REQ-034 SHALL cover this scenario: rst_n low for 1 cycle mid-RUN at count1=2 -> the next cycle shows all outputs 0, state IDLE, no finished pulse.
REQ-035 SHALL cover this scenario: start pulsed during RUN -> ignored, counts continue. Start in DONE -> counts clear and a new race begins.
REQ-036 SHALL cover this scenario: with RACE_TIMEOUT_EN, TIMEOUT_CYC=50, ROs held low -> timeout=1 after 50 RUN cycles, finished both 0. Without the macro, timeout stays 0 and busy stays 1.
